fpga_cfg_loader: RTL and testbench

//  Bitstream loader/verifier for the parametrised N x N fabric. Takes a word-wide ready/valid stream and

---
 rtl/fpga_cfg_loader_if.sv | 12 +
 rtl/fpga_cfg_loader.sv | 147 ++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_cfg_loader_if.sv
// Configuration word stream between the external config port (master) and the loader (slave).
// A word transfers on any rising edge where cfg_valid && cfg_ready; cfg_data must be stable while cfg_valid waits.
interface fpga_cfg_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fpga_cfg_loader.sv
// Serialises a word stream into the fabric's conn scan chain, then its clb scan chain.
// Verify mode re-shifts the same stream and counts tail bits that differ from the bit shifted in.
module fpga_cfg_loader #(
  parameter int WORD_W         = 8,
  parameter int CONN_CHAIN_LEN = 128,
  parameter int CLB_CHAIN_LEN  = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_abort,
  fpga_cfg_loader_if.slave cfg_if,
  output logic             o_conn_scan_in,
  input  logic             i_conn_scan_out,
  output logic             o_conn_scan_en,
  output logic             o_clb_scan_in,
  input  logic             i_clb_scan_out,
  output logic             o_clb_scan_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [CNT_W-1:0] o_mismatch_cnt,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONN = 2'd1,
    S_CLB  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam int MAX_LEN = (CONN_CHAIN_LEN > CLB_CHAIN_LEN) ? CONN_CHAIN_LEN : CLB_CHAIN_LEN;
  localparam int BW      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);
  localparam logic [CW-1:0] CONN_LAST = CW'(CONN_CHAIN_LEN - 1);
  localparam logic [CW-1:0] CLB_LAST  = CW'(CLB_CHAIN_LEN - 1);

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_buf;
  logic              r_buf_full;
  logic [BW-1:0]     r_bit_idx;
  logic [CW-1:0]     r_shift_cnt;
  logic              r_mode;
  logic              r_done;
  logic              r_error;
  logic [CNT_W-1:0]  r_mismatch;

  logic w_active, w_shift, w_bit, w_seg_end, w_buf_end, w_final;
  logic w_start, w_abort, w_ready, w_accept, w_tail, w_miss;

  assign w_active  = (r_state == S_CONN) || (r_state == S_CLB);
  assign w_shift   = w_active && r_buf_full;
  assign w_bit     = r_buf[r_bit_idx];
  assign w_seg_end = w_shift && (r_shift_cnt == ((r_state == S_CONN) ? CONN_LAST : CLB_LAST));
  // A segment's last word may be partially used; its padding bits are dropped here.
  assign w_buf_end = w_shift && ((r_bit_idx == LAST_BIT) || w_seg_end);
  assign w_final   = w_seg_end && (r_state == S_CLB);
  assign w_start   = (r_state == S_IDLE) && i_start;
  assign w_abort   = i_abort && (r_state != S_IDLE);
  // No word is requested beyond the end of the clb segment.
  assign w_ready   = w_active && (!r_buf_full || w_buf_end) && !w_final;
  assign w_accept  = w_ready && cfg_if.cfg_valid;
  assign w_tail    = (r_state == S_CONN) ? i_conn_scan_out : i_clb_scan_out;
  assign w_miss    = w_shift && r_mode && (w_tail != w_bit) && (r_mismatch != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (i_start) w_next = S_CONN;
      S_CONN: begin
        if (w_abort)        w_next = S_IDLE;
        else if (w_seg_end) w_next = S_CLB;
      end
      S_CLB: begin
        if (w_abort)        w_next = S_IDLE;
        else if (w_seg_end) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_bit_idx   <= '0;
      r_shift_cnt <= '0;
      r_mode      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_mismatch  <= '0;
    end else if (w_start) begin
      r_mode      <= i_mode;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_mismatch  <= '0;
      r_buf_full  <= 1'b0;
      r_bit_idx   <= '0;
      r_shift_cnt <= '0;
    end else if (w_abort) begin
      r_error     <= 1'b1;
      r_done      <= 1'b0;
      r_buf_full  <= 1'b0;
      r_bit_idx   <= '0;
      r_shift_cnt <= '0;
    end else begin
      if (r_state == S_FIN) r_done <= 1'b1;
      if (w_shift) begin
        r_shift_cnt <= w_seg_end ? '0 : r_shift_cnt + CW'(1);
        r_bit_idx   <= r_bit_idx + BW'(1);
        if (w_miss) r_mismatch <= r_mismatch + CNT_W'(1);
      end
      if (w_accept) begin
        r_buf      <= cfg_if.cfg_data;
        r_buf_full <= 1'b1;
        r_bit_idx  <= '0;
      end else if (w_buf_end) begin
        r_buf_full <= 1'b0;
        r_bit_idx  <= '0;
      end
    end
  end

  assign cfg_if.cfg_ready = w_ready;
  assign o_conn_scan_en   = (r_state == S_CONN) && r_buf_full;
  assign o_conn_scan_in   = o_conn_scan_en && w_bit;
  assign o_clb_scan_en    = (r_state == S_CLB) && r_buf_full;
  assign o_clb_scan_in    = o_clb_scan_en && w_bit;
  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = r_done;
  assign o_error          = r_error;
  assign o_mismatch_cnt   = r_mismatch;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: 12-bit conn and 8-bit clb chains modelled as shift registers,
// a stream model that predicts every shifted bit, and directed program/verify/abort/reset scenarios.
module tb_fpga_cfg_loader;
  localparam int WORD_W = 8;
  localparam int CONN_L = 12;
  localparam int CLB_L  = 8;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start, mode, abort;
  logic conn_in, conn_out, conn_en, clb_in, clb_out, clb_en;
  logic busy, done, error;
  logic [CNT_W-1:0] mism;
  logic [1:0] dbg_state;

  fpga_cfg_loader_if #(.WORD_W(WORD_W)) cfg_bus ();

  fpga_cfg_loader #(
    .WORD_W(WORD_W), .CONN_CHAIN_LEN(CONN_L), .CLB_CHAIN_LEN(CLB_L), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_mode(mode), .i_abort(abort),
    .cfg_if(cfg_bus.slave),
    .o_conn_scan_in(conn_in), .i_conn_scan_out(conn_out), .o_conn_scan_en(conn_en),
    .o_clb_scan_in(clb_in), .i_clb_scan_out(clb_out), .o_clb_scan_en(clb_en),
    .o_busy(busy), .o_done(done), .o_error(error), .o_mismatch_cnt(mism),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Fabric model: first bit shifted ends at chain[0], the tail.
  logic [CONN_L-1:0] conn_chain = '0;
  logic [CLB_L-1:0]  clb_chain  = '0;
  logic              flip_req = 1'b0;
  logic [CLB_L-1:0]  flip_mask = '0;
  assign conn_out = conn_chain[0];
  assign clb_out  = clb_chain[0];

  always @(posedge clk) begin
    if (conn_en) conn_chain <= {conn_in, conn_chain[CONN_L-1:1]};
    if (clb_en)        clb_chain <= {clb_in, clb_chain[CLB_L-1:1]};
    else if (flip_req) clb_chain <= clb_chain ^ flip_mask;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream model
  logic exp_conn_q[$];
  logic exp_clb_q[$];
  logic [CONN_L-1:0] stream_conn;
  logic [CLB_L-1:0]  stream_clb;
  int conn_shifts, clb_shifts, hs_cnt, idle_busy;

  task automatic prep(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
    logic [7:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    exp_conn_q.delete();
    exp_clb_q.delete();
    for (int i = 0; i < CONN_L; i++) begin
      exp_conn_q.push_back(w[i/8][i%8]);
      stream_conn[i] = w[i/8][i%8];
    end
    for (int i = 0; i < CLB_L; i++) begin
      exp_clb_q.push_back(w[2 + i/8][i%8]);
      stream_clb[i] = w[2 + i/8][i%8];
    end
    conn_shifts = 0; clb_shifts = 0; hs_cnt = 0; idle_busy = 0;
  endtask

  // Per-cycle compare against the stream model
  always @(negedge clk) begin
    if (busy) begin
      chk("en_excl", {31'd0, conn_en & clb_en}, 0);
      if (conn_en) begin
        conn_shifts++;
        if (exp_conn_q.size() == 0) chk("conn_extra_shift", 1, 0);
        else chk("conn_bit", {31'd0, conn_in}, {31'd0, exp_conn_q.pop_front()});
      end else chk("conn_idle_in", {31'd0, conn_in}, 0);
      if (clb_en) begin
        clb_shifts++;
        chk("clb_before_conn_done", exp_conn_q.size(), 0);
        if (exp_clb_q.size() == 0) chk("clb_extra_shift", 1, 0);
        else chk("clb_bit", {31'd0, clb_in}, {31'd0, exp_clb_q.pop_front()});
      end else chk("clb_idle_in", {31'd0, clb_in}, 0);
      if (!conn_en && !clb_en) idle_busy++;
    end else begin
      chk("idle_ready", {31'd0, cfg_bus.cfg_ready}, 0);
      chk("idle_en", {30'd0, conn_en, clb_en}, 0);
    end
    if (cfg_bus.cfg_valid && cfg_bus.cfg_ready) hs_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs();
    logic got;
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = cfg_bus.cfg_ready;
      step();
      n++;
    end
    chk("handshake_timeout", {31'd0, got}, 1);
  endtask

  int lat;
  int mm_exp;

  task automatic run_op(input logic m, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input int gap, input logic glitch);
    logic [7:0] w [3];
    int c0, n, d;
    w[0] = w0; w[1] = w1; w[2] = w2;
    prep(w0, w1, w2);
    d = $countones(conn_chain ^ stream_conn) + $countones(clb_chain ^ stream_clb);
    mm_exp = m ? ((d > 3) ? 3 : d) : 0;
    start = 1'b1; mode = m;
    step();
    start = 1'b0; mode = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      cfg_bus.cfg_data = w[k];
      cfg_bus.cfg_valid = 1'b1;
      wait_hs();
      if (k == 0 && gap > 0) begin
        cfg_bus.cfg_valid = 1'b0;
        n = 0;
        while (!cfg_bus.cfg_ready && n < 50) begin step(); n++; end
        repeat (gap) step();
      end
    end
    cfg_bus.cfg_valid = 1'b0;
    if (glitch) begin
      start = 1'b1; mode = 1'b1;
      step();
      start = 1'b0; mode = 1'b0;
    end
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    chk("done_timeout", {31'd0, busy}, 0);
    lat = cyc - c0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    cfg_bus.cfg_data = '0; cfg_bus.cfg_valid = 1'b0;
    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_error", {31'd0, error}, 0);
    chk("rst_mism", {30'd0, mism}, 0);
    chk("rst_ready", {31'd0, cfg_bus.cfg_ready}, 0);
    chk("rst_state", {30'd0, dbg_state}, 0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of the conn segment
    prep(8'hA5, 8'h03, 8'h3C);
    start = 1'b1; step(); start = 1'b0;
    cfg_bus.cfg_data = 8'hA5; cfg_bus.cfg_valid = 1'b1;
    repeat (4) step();
    chk("midconn_en", {31'd0, conn_en}, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", {30'd0, conn_en, clb_en}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_ready", {31'd0, cfg_bus.cfg_ready}, 0);
    chk("async_rst_flags", {29'd0, done, error, conn_in}, 0);
    step();
    cfg_bus.cfg_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_ready", {31'd0, cfg_bus.cfg_ready}, 0);

    // Program, zero-bubble
    run_op(1'b0, 8'hA5, 8'h03, 8'h3C, 0, 1'b0);
    chk("prog_latency", lat, 22);
    chk("prog_handshakes", hs_cnt, 3);
    chk("prog_conn_shifts", conn_shifts, CONN_L);
    chk("prog_clb_shifts", clb_shifts, CLB_L);
    chk("prog_model_conn", {20'd0, stream_conn}, 32'h3A5);
    chk("prog_conn_chain", {20'd0, conn_chain}, 32'h3A5);
    chk("prog_clb_chain", {24'd0, clb_chain}, 32'h3C);
    chk("prog_done", {30'd0, done, error}, 2);
    chk("prog_mism", {30'd0, mism}, 0);
    chk("prog_stall_cycles", idle_busy, 2);

    // Program with a 5-cycle source stall between the first two words
    run_op(1'b0, 8'h5A, 8'h0C, 8'hC3, 5, 1'b0);
    chk("stall_latency", lat, 27);
    chk("stall_cycles", idle_busy, 7);
    chk("stall_conn_chain", {20'd0, conn_chain}, {20'd0, stream_conn});
    chk("stall_conn_lit", {20'd0, conn_chain}, 32'hC5A);
    chk("stall_clb_chain", {24'd0, clb_chain}, 32'hC3);
    chk("stall_handshakes", hs_cnt, 3);

    // Verify a different stream: 20 mismatches saturate at 3
    run_op(1'b1, 8'hA5, 8'h03, 8'h3C, 0, 1'b0);
    chk("sat_model", mm_exp, 3);
    chk("sat_mism", {30'd0, mism}, mm_exp[31:0]);
    chk("sat_done", {31'd0, done}, 1);

    // Verify the same stream: no mismatches
    run_op(1'b1, 8'hA5, 8'h03, 8'h3C, 0, 1'b0);
    chk("ver_model", mm_exp, 0);
    chk("ver_mism", {30'd0, mism}, mm_exp[31:0]);
    chk("ver_done", {30'd0, done, error}, 2);
    chk("ver_latency", lat, 22);

    // Flip one clb bit in the fabric, verify again
    flip_mask = 8'h20; flip_req = 1'b1;
    step();
    flip_req = 1'b0;
    run_op(1'b1, 8'hA5, 8'h03, 8'h3C, 0, 1'b0);
    chk("flip_model", mm_exp, 1);
    chk("flip_mism", {30'd0, mism}, mm_exp[31:0]);
    chk("flip_restored", {24'd0, clb_chain}, 32'h3C);

    // Abort after 6 conn shifts
    prep(8'hFF, 8'hFF, 8'hFF);
    start = 1'b1; step(); start = 1'b0;
    cfg_bus.cfg_data = 8'hFF; cfg_bus.cfg_valid = 1'b1;
    wait_hs();
    cfg_bus.cfg_valid = 1'b0;
    n = 0;
    while (conn_shifts < 6 && n < 50) begin step(); n++; end
    chk("abort_reach6", conn_shifts, 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_flags", {29'd0, busy, done, error}, 1);
    chk("abort_en_low", {30'd0, conn_en, clb_en}, 0);
    chk("abort_ready_low", {31'd0, cfg_bus.cfg_ready}, 0);
    step();
    chk("abort_err_held", {31'd0, error}, 1);

    // Clean program afterwards, with start pulsed while busy
    run_op(1'b0, 8'hA5, 8'h03, 8'h3C, 0, 1'b1);
    chk("reprog_flags", {30'd0, done, error}, 2);
    chk("reprog_latency", lat, 22);
    chk("reprog_conn_shifts", conn_shifts, CONN_L);
    chk("reprog_clb_shifts", clb_shifts, CLB_L);
    chk("reprog_conn_chain", {20'd0, conn_chain}, 32'h3A5);
    chk("reprog_clb_chain", {24'd0, clb_chain}, 32'h3C);
    chk("reprog_mism", {30'd0, mism}, 0);
    step();
    chk("final_idle", {30'd0, dbg_state}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
